// File: rtl/adc_cap_pkg.sv
// rtl/adc_cap_pkg.sv - shared state encoding and mode constants for the ADC capture sequencer
package adc_cap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SKIP = 3'd1,
        ST_PRE  = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } cap_state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_TRIG    = 1'b1;

endpackage

// File: rtl/adc_cap_sat_cnt.sv
// rtl/adc_cap_sat_cnt.sv - saturating up-counter with synchronous clear and runtime ceiling
module adc_cap_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != max_val)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - capture sequencer driving the ADC capture buffer write port
module adc_capture_ctrl
    import adc_cap_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic              cfg_src_sel,
    input  logic              cfg_mode,
    input  logic [LEN_W-1:0]  cfg_skip,
    input  logic [LEN_W-1:0]  cfg_pre,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              trig_in,
    input  logic              frame_valid,
    input  logic              wr_ready,
    output logic              src_sel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [LEN_W-1:0]  frames_written,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state
);

    cap_state_t        state_q, state_d;
    logic              mode_q;
    logic [LEN_W-1:0]  skip_q, pre_q, len_q;
    logic [LEN_W-1:0]  skip_cnt, post_cnt, pre_cnt;
    logic [ADDR_W-1:0] addr_ptr;

    logic fire_start, trig_hit, write_open, accept, drop;

    always_comb begin
        fire_start = cfg_start && !cfg_abort && (state_q == ST_IDLE || state_q == ST_DONE);
        trig_hit   = (state_q == ST_PRE) && trig_in && (pre_cnt == pre_q);
        // With len 0 the post phase writes nothing, including a frame that coincides with the trigger.
        write_open = 1'b0;
        if (state_q == ST_POST) begin
            write_open = (len_q != '0);
        end else if (state_q == ST_PRE) begin
            write_open = !trig_hit || (len_q != '0);
        end
        accept = !cfg_abort && write_open && frame_valid && wr_ready;
        drop   = !cfg_abort && write_open && frame_valid && !wr_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cfg_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (cfg_start) state_d = ST_SKIP;
                end
                ST_SKIP: begin
                    if ((skip_q == '0) || (frame_valid && (skip_cnt + LEN_W'(1) == skip_q))) begin
                        state_d = (mode_q == MODE_TRIG) ? ST_PRE : ST_POST;
                    end
                end
                ST_PRE: begin
                    if (trig_hit) begin
                        state_d = (accept && (len_q == LEN_W'(1))) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if ((len_q == '0) || (accept && (post_cnt + LEN_W'(1) == len_q))) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_sel        <= 1'b0;
            mode_q         <= MODE_ONESHOT;
            skip_q         <= '0;
            pre_q          <= '0;
            len_q          <= '0;
            skip_cnt       <= '0;
            post_cnt       <= '0;
            addr_ptr       <= '0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            trig_addr      <= '0;
            frames_written <= '0;
        end else begin
            wr_en <= accept;
            if (fire_start) begin
                src_sel        <= cfg_src_sel;
                mode_q         <= cfg_mode;
                skip_q         <= cfg_skip;
                pre_q          <= cfg_pre;
                len_q          <= cfg_len;
                skip_cnt       <= '0;
                post_cnt       <= '0;
                addr_ptr       <= '0;
                wr_addr        <= '0;
                frames_written <= '0;
            end else begin
                if (state_q == ST_SKIP && frame_valid) begin
                    skip_cnt <= skip_cnt + LEN_W'(1);
                end
                // wr_addr presents the address of the write now on wr_en; addr_ptr is the next free slot.
                if (accept) begin
                    wr_addr        <= addr_ptr;
                    addr_ptr       <= addr_ptr + ADDR_W'(1);
                    frames_written <= frames_written + LEN_W'(1);
                end
                if (trig_hit && !cfg_abort) begin
                    trig_addr <= addr_ptr;
                    post_cnt  <= accept ? LEN_W'(1) : '0;
                end else if (state_q == ST_POST && accept) begin
                    post_cnt <= post_cnt + LEN_W'(1);
                end
            end
        end
    end

    adc_cap_sat_cnt #(.W(DROP_W)) u_drop_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (fire_start),
        .inc     (drop),
        .max_val ({DROP_W{1'b1}}),
        .count   (drop_cnt)
    );

    adc_cap_sat_cnt #(.W(LEN_W)) u_pre_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (fire_start),
        .inc     ((state_q == ST_PRE) && accept && !trig_hit),
        .max_val (pre_q),
        .count   (pre_cnt)
    );

    assign state = state_q;
    assign busy  = (state_q == ST_SKIP) || (state_q == ST_PRE) || (state_q == ST_POST);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - self-checking bench for adc_capture_ctrl
module tb_adc_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int LEN_W  = 16;
    localparam int DROP_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_start = 1'b0, cfg_abort = 1'b0, cfg_src_sel = 1'b0, cfg_mode = 1'b0;
    logic [LEN_W-1:0]  cfg_skip = '0, cfg_pre = '0, cfg_len = '0;
    logic              trig_in = 1'b0, frame_valid = 1'b0, wr_ready = 1'b0;
    logic              src_sel, wr_en, busy, done;
    logic [ADDR_W-1:0] wr_addr, trig_addr;
    logic [LEN_W-1:0]  frames_written;
    logic [DROP_W-1:0] drop_cnt;
    logic [2:0]        state;

    int total = 0;
    int bad = 0;
    int obs[$];
    int expq[$];

    typedef struct {
        logic fv;
        logic rdy;
        logic trig;
        logic e_wr_en;
        int   e_addr;
        int   e_state;
    } vec_t;
    vec_t tbl[10];

    // reference model bookkeeping (phase numbers are the documented state values)
    int m_phase, m_skip, m_pre, m_len, m_mode;
    int m_seen_skip, m_seen_pre, m_seen_post, m_ptr, m_nwr, m_ndrop, m_trig;
    bit m_trig_valid;

    adc_capture_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_src_sel(cfg_src_sel), .cfg_mode(cfg_mode), .cfg_skip(cfg_skip),
        .cfg_pre(cfg_pre), .cfg_len(cfg_len), .trig_in(trig_in),
        .frame_valid(frame_valid), .wr_ready(wr_ready), .src_sel(src_sel),
        .wr_en(wr_en), .wr_addr(wr_addr), .trig_addr(trig_addr),
        .frames_written(frames_written), .drop_cnt(drop_cnt), .busy(busy),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && wr_en) obs.push_back(int'(wr_addr));
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_writes(input string name);
        chk({name, "_count"}, obs.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            if (obs[i] != expq[i]) begin
                chk({name, "_addr"}, obs[i], expq[i]);
                break;
            end
        end
    endtask

    task automatic cyc(input logic fv, input logic rdy, input logic trig);
        frame_valid = fv;
        wr_ready    = rdy;
        trig_in     = trig;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        trig_in     = 1'b0;
    endtask

    task automatic start_cap(input logic src, input logic mode, input int skip, input int pre, input int len);
        cfg_src_sel = src;
        cfg_mode    = mode;
        cfg_skip    = LEN_W'(skip);
        cfg_pre     = LEN_W'(pre);
        cfg_len     = LEN_W'(len);
        cfg_start   = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        obs.delete();
        expq.delete();
    endtask

    task automatic abort_cap();
        cfg_abort = 1'b1;
        @(posedge clk);
        #1;
        cfg_abort = 1'b0;
    endtask

    task automatic m_write();
        expq.push_back(m_ptr);
        m_ptr = (m_ptr + 1) % DEPTH;
        m_nwr++;
    endtask

    task automatic model_step(input bit fv, input bit rdy, input bit trig);
        case (m_phase)
            1: begin
                if (m_skip == 0) m_phase = m_mode ? 2 : 3;
                else if (fv) begin
                    m_seen_skip++;
                    if (m_seen_skip == m_skip) m_phase = m_mode ? 2 : 3;
                end
            end
            2: begin
                if (trig && m_seen_pre >= m_pre) begin
                    m_trig = m_ptr;
                    m_trig_valid = 1;
                    if (m_len == 0) m_phase = 3;
                    else begin
                        m_seen_post = 0;
                        if (fv && rdy) begin m_write(); m_seen_post = 1; end
                        else if (fv) m_ndrop++;
                        m_phase = (m_seen_post == m_len) ? 4 : 3;
                    end
                end else if (fv) begin
                    if (rdy) begin m_write(); m_seen_pre++; end
                    else m_ndrop++;
                end
            end
            3: begin
                if (m_len == 0) m_phase = 4;
                else if (fv) begin
                    if (rdy) begin
                        m_write();
                        m_seen_post++;
                        if (m_seen_post == m_len) m_phase = 4;
                    end else m_ndrop++;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", state, 0);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_busy_done", {busy, done}, 0);
        chk("reset_counts", frames_written + drop_cnt + trig_addr + src_sel, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // one-shot, skip 2, len 5, ten back-to-back frames
        tbl[0] = '{1, 1, 0, 0, 0, 1};
        tbl[1] = '{1, 1, 0, 0, 0, 3};
        tbl[2] = '{1, 1, 0, 1, 0, 3};
        tbl[3] = '{1, 1, 0, 1, 1, 3};
        tbl[4] = '{1, 1, 0, 1, 2, 3};
        tbl[5] = '{1, 1, 0, 1, 3, 3};
        tbl[6] = '{1, 1, 0, 1, 4, 4};
        tbl[7] = '{1, 1, 0, 0, 4, 4};
        tbl[8] = '{1, 1, 0, 0, 4, 4};
        tbl[9] = '{1, 1, 0, 0, 4, 4};
        start_cap(0, 0, 2, 0, 5);
        chk("oneshot_skip_state", state, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].fv, tbl[i].rdy, tbl[i].trig);
            chk($sformatf("oneshot_wr_en_%0d", i), wr_en, tbl[i].e_wr_en);
            if (tbl[i].e_wr_en) chk($sformatf("oneshot_addr_%0d", i), wr_addr, tbl[i].e_addr);
            chk($sformatf("oneshot_state_%0d", i), state, tbl[i].e_state);
        end
        chk("oneshot_done", done, 1);
        chk("oneshot_frames", frames_written, 5);

        // triggered: early trigger ignored, second one qualified
        start_cap(0, 1, 0, 3, 4);
        cyc(0, 1, 0);
        chk("trig_pre_state", state, 2);
        cyc(1, 1, 0);
        cyc(0, 1, 1);
        chk("trig_early_ignored", state, 2);
        repeat (5) cyc(1, 1, 0);
        cyc(0, 1, 1);
        chk("trig_post_state", state, 3);
        chk("trig_addr", trig_addr, 6);
        repeat (4) cyc(1, 1, 0);
        chk("trig_done", state, 4);
        cyc(0, 1, 0);
        for (int i = 0; i < 10; i++) expq.push_back(i);
        chk_writes("trig_writes");
        chk("trig_frames", frames_written, 10);

        // backpressure
        start_cap(0, 0, 0, 0, 4);
        cyc(0, 1, 0);
        cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0);
        chk("bp_done", state, 4);
        chk("bp_drop", drop_cnt, 2);
        cyc(0, 1, 0);
        for (int i = 0; i < 4; i++) expq.push_back(i);
        chk_writes("bp_writes");
        start_cap(0, 0, 0, 0, 1);
        cyc(0, 1, 0);
        repeat (300) cyc(1, 0, 0);
        chk("drop_saturate", drop_cnt, 255);
        chk("drop_still_post", state, 3);
        abort_cap();

        // address wrap
        start_cap(0, 0, 0, 0, 20);
        cyc(0, 1, 0);
        repeat (19) cyc(1, 1, 0);
        chk("wrap_not_done", state, 3);
        cyc(1, 1, 0);
        chk("wrap_done", state, 4);
        cyc(0, 1, 0);
        for (int i = 0; i < 20; i++) expq.push_back(i % DEPTH);
        chk_writes("wrap_writes");

        // len 0
        start_cap(0, 0, 0, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        chk("len0_state", state, 4);
        chk_writes("len0_writes");

        // trigger coincident with a frame
        start_cap(0, 1, 0, 0, 2);
        cyc(0, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 1);
        chk("coinc_state", state, 3);
        chk("coinc_trig_addr", trig_addr, 2);
        cyc(1, 1, 0);
        chk("coinc_done", state, 4);
        cyc(0, 1, 0);
        for (int i = 0; i < 4; i++) expq.push_back(i);
        chk_writes("coinc_writes");

        // start while busy ignored
        start_cap(0, 0, 3, 0, 2);
        cfg_src_sel = 1'b1;
        cfg_start   = 1'b1;
        cyc(0, 1, 0);
        cfg_start = 1'b0;
        chk("busy_start_state", state, 1);
        chk("busy_start_src", src_sel, 0);
        abort_cap();

        // abort in PRE
        start_cap(1, 1, 0, 5, 3);
        cyc(0, 1, 0);
        chk("abort_src_sel", src_sel, 1);
        cyc(1, 1, 0);
        cfg_abort = 1'b1;
        cfg_start = 1'b1;
        cyc(0, 1, 0);
        cfg_abort = 1'b0;
        cfg_start = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_done", done, 0);

        // asynchronous reset mid-POST
        start_cap(0, 0, 0, 0, 10);
        cyc(0, 1, 0);
        frame_valid = 1'b1;
        wr_ready    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_wr_en", wr_en, 0);
        chk("areset_state", state, 0);
        chk("areset_addr_frames", wr_addr + frames_written, 0);
        frame_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // randomized captures against the reference model
        for (int r = 0; r < 12; r++) begin
            m_mode = $urandom_range(1, 0);
            m_skip = $urandom_range(3, 0);
            m_pre  = $urandom_range(3, 0);
            m_len  = $urandom_range(6, 0);
            start_cap(1'($urandom_range(1, 0)), 1'(m_mode), m_skip, m_pre, m_len);
            m_phase = 1; m_seen_skip = 0; m_seen_pre = 0; m_seen_post = 0;
            m_ptr = 0; m_nwr = 0; m_ndrop = 0; m_trig = 0; m_trig_valid = 0;
            for (int c = 0; c < 42; c++) begin
                bit fv, rdy, tg;
                fv  = (c < 40) && ($urandom_range(99, 0) < 60);
                rdy = $urandom_range(99, 0) < 75;
                tg  = (c < 40) && ($urandom_range(99, 0) < 30);
                model_step(fv, rdy, tg);
                cyc(fv, rdy, tg);
            end
            chk_writes($sformatf("rand%0d_writes", r));
            chk($sformatf("rand%0d_state", r), state, m_phase);
            chk($sformatf("rand%0d_frames", r), frames_written, m_nwr);
            chk($sformatf("rand%0d_drop", r), drop_cnt, (m_ndrop > 255) ? 255 : m_ndrop);
            if (m_trig_valid) chk($sformatf("rand%0d_trig_addr", r), trig_addr, m_trig);
            abort_cap();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
